mem_ram: RTL and testbench

// - Single-port synchronous RAM slave with a valid/ready request handshake.
// - A master (testbench driver via interface bundle) issues one write or read per handshake.
// - Write stores wdata at addr; read returns mem[addr] on rdata.
// - Carries its own protocol checks; a companion checker observing the same pins must see no violation.

---
 rtl/mem_ram.sv | 69 ++++++
 tb/tb_mem_ram.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_ram.sv
// Single-port synchronous RAM slave with a valid/ready request handshake.
// One read or write per accepted cycle; async active-high reset clears all storage.
module mem_ram #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              res,
    input  logic              wr_rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              valid,
    output logic [WIDTH-1:0]  rdata,
    output logic              ready
);

    logic [WIDTH-1:0] mem [DEPTH];

    // A held request is re-sampled each edge; rewriting identical data keeps it idempotent.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= valid;
            if (valid) begin
                if (wr_rd) begin
                    mem[addr] <= wdata;
                end else begin
                    rdata <= mem[addr];
                end
            end
        end
    end

    // Protocol checks on the master-facing pins; ignored by synthesis.
    a_valid_held: assert property (@(posedge clk) disable iff (res)
        (valid && !ready) |=> valid)
        else $error("mem_ram: valid dropped before ready");

    a_req_stable: assert property (@(posedge clk) disable iff (res)
        (valid && !ready) |=> ($stable(wr_rd) && $stable(addr) && $stable(wdata)))
        else $error("mem_ram: request changed while waiting for ready");

    a_ctrl_known: assert property (@(posedge clk) disable iff (res)
        valid |-> !$isunknown({wr_rd, addr}))
        else $error("mem_ram: wr_rd/addr unknown while valid");

    a_wdata_known: assert property (@(posedge clk) disable iff (res)
        (valid && wr_rd) |-> !$isunknown(wdata))
        else $error("mem_ram: wdata unknown on write");

    a_ready_in_reset: assert property (@(posedge clk)
        res |-> !ready)
        else $error("mem_ram: ready high during reset");

    a_ready_after_reset: assert property (@(posedge clk)
        $fell(res) |-> !ready)
        else $error("mem_ram: ready high right after reset release");

    a_ready_needs_valid: assert property (@(posedge clk) disable iff (res)
        !valid |=> !ready)
        else $error("mem_ram: ready without prior valid");

endmodule

// File: tb/tb_mem_ram.sv
// Directed + randomized bench for mem_ram, scored against an array model of the RAM.
module tb_mem_ram;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic              clk = 1'b0;
    logic              res;
    logic              wr_rd;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic              valid;
    logic [WIDTH-1:0]  rdata;
    logic              ready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] model [DEPTH];

    mem_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .res   (res),
        .wr_rd (wr_rd),
        .addr  (addr),
        .wdata (wdata),
        .valid (valid),
        .rdata (rdata),
        .ready (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    endtask

    // Called at a negedge; returns at the negedge after the completing edge.
    task automatic req(input logic wr, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        logic rdy;
        int   budget;
        valid = 1'b1;
        wr_rd = wr;
        addr  = a;
        wdata = d;
        budget = 0;
        do begin
            rdy = ready;
            @(posedge clk);
            @(negedge clk);
            budget++;
        end while (!rdy && budget < 8);
        if (!rdy) check("handshake_timeout", 16'(ready), 16'd1);
        if (wr) model[a] = d;
    endtask

    task automatic idle();
        valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [ADDR_W-1:0] a);
        req(1'b0, a, 16'h0000);
        check(tag, rdata, model[a]);
    endtask

    initial begin
        res   = 1'b1;
        valid = 1'b0;
        wr_rd = 1'b0;
        addr  = '0;
        wdata = '0;
        model_clear();

        // Reset held over the first two edges.
        @(posedge clk);
        @(negedge clk);
        check("reset_ready", 16'(ready), 16'd0);
        check("reset_rdata", rdata, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        res = 1'b0;
        idle();
        check("post_reset_ready", 16'(ready), 16'd0);
        check("post_reset_rdata", rdata, 16'h0000);
        read_check("read_addr5_after_reset", 4'd5);
        check("read_addr5_value", rdata, 16'h0000);
        idle();

        // Write then read back.
        req(1'b1, 4'd3, 16'hA5A5);
        idle();
        req(1'b0, 4'd3, 16'h0000);
        check("readback_addr3", rdata, 16'hA5A5);
        check("readback_ready", 16'(ready), 16'd1);
        idle();

        // Address boundaries and neighbours.
        req(1'b1, 4'd0, 16'h1111);
        req(1'b1, 4'd15, 16'hFFFF);
        idle();
        read_check("bound_addr0", 4'd0);
        check("bound_addr0_const", rdata, 16'h1111);
        read_check("bound_addr15", 4'd15);
        check("bound_addr15_const", rdata, 16'hFFFF);
        read_check("neigh_addr1", 4'd1);
        read_check("neigh_addr14", 4'd14);
        idle();

        // Back-to-back overwrite then read: ready must stay high.
        req(1'b1, 4'd7, 16'h0001);
        check("b2b_ready_w1", 16'(ready), 16'd1);
        req(1'b1, 4'd7, 16'h0002);
        check("b2b_ready_w2", 16'(ready), 16'd1);
        req(1'b0, 4'd7, 16'h0000);
        check("b2b_ready_rd", 16'(ready), 16'd1);
        check("b2b_rdata", rdata, 16'h0002);
        idle();
        check("idle_ready_low", 16'(ready), 16'd0);

        // Random writes then random reads against the model.
        for (int i = 0; i < 16; i++) begin
            req(1'b1, ADDR_W'($urandom_range(DEPTH - 1)), WIDTH'($urandom));
            if ($urandom_range(1) == 0) idle();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            read_check("rand_read", ADDR_W'($urandom_range(DEPTH - 1)));
            if ($urandom_range(1) == 0) idle();
        end
        idle();

        // Reset while a write to addr 9 is in flight.
        valid = 1'b1;
        wr_rd = 1'b1;
        addr  = 4'd9;
        wdata = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        check("midop_ready_before", 16'(ready), 16'd1);
        res = 1'b1;
        #1;
        check("midop_ready_drop", 16'(ready), 16'd0);
        check("midop_rdata_clear", rdata, 16'h0000);
        valid = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        res = 1'b0;
        idle();
        read_check("midop_addr9", 4'd9);
        check("midop_addr9_zero", rdata, 16'h0000);
        read_check("midop_addr3_cleared", 4'd3);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
